sc_max7219rx: RTL and testbench

//  Receive-side model of the MAX7219 serial interface (DIN/NCS/CLK) that matrix_ctrl drives.

---
 rtl/sc_max7219_pkg.sv | 47 ++++
 rtl/sc_max7219rx_if.sv | 50 +++++
 rtl/sc_max7219rx_sync.sv | 31 +++
 rtl/sc_max7219rx.sv | 142 ++++++++++++++
 tb/tb_sc_max7219rx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_max7219_pkg.sv
// Shared constants for the MAX7219 receive mirror: register addresses, FSM states, reset values.
package sc_max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_LATCH     = 2'd3
  } state_t;

  localparam logic [7:0] RST_DECODE    = 8'h00;
  localparam logic [3:0] RST_INTENSITY = 4'h0;
  localparam logic [2:0] RST_SCANLIMIT = 3'h0;
  localparam logic       RST_SHUTDOWN  = 1'b1;
  localparam logic       RST_DISPTEST  = 1'b0;

  // Row slot for a digit address; 4'hF marks a non-digit address.
  function automatic logic [3:0] digit_slot(input logic [3:0] addr);
    case (addr)
      ADDR_DIGIT0: return 4'd0;
      ADDR_DIGIT1: return 4'd1;
      ADDR_DIGIT2: return 4'd2;
      ADDR_DIGIT3: return 4'd3;
      ADDR_DIGIT4: return 4'd4;
      ADDR_DIGIT5: return 4'd5;
      ADDR_DIGIT6: return 4'd6;
      ADDR_DIGIT7: return 4'd7;
      default:     return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/sc_max7219rx_if.sv
// Serial pins in, mirrored register file out. dout exists only with SC_MAX7219RX_DOUT_EN.
interface sc_max7219rx_if #(parameter int DIGITS = 8);

  logic                  SC_MAX7219RX_din_In;
  logic                  SC_MAX7219RX_ncs_In;
  logic                  SC_MAX7219RX_sclk_In;
  logic [8*DIGITS-1:0]   SC_MAX7219RX_rows_OutBUS;
  logic [7:0]            SC_MAX7219RX_decode_OutBUS;
  logic [3:0]            SC_MAX7219RX_intensity_Out;
  logic [2:0]            SC_MAX7219RX_scanlimit_Out;
  logic                  SC_MAX7219RX_shutdown_Out;
  logic                  SC_MAX7219RX_disptest_Out;
  logic [15:0]           SC_MAX7219RX_word_OutBUS;
  logic                  SC_MAX7219RX_wordvalid_Out;
  logic                  SC_MAX7219RX_frameerr_Out;
`ifdef SC_MAX7219RX_DOUT_EN
  logic                  SC_MAX7219RX_dout_Out;

  modport master (
    output SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
    input  SC_MAX7219RX_rows_OutBUS, SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_intensity_Out,
           SC_MAX7219RX_scanlimit_Out, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_disptest_Out,
           SC_MAX7219RX_word_OutBUS, SC_MAX7219RX_wordvalid_Out, SC_MAX7219RX_frameerr_Out,
           SC_MAX7219RX_dout_Out
  );

  modport slave (
    input  SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
    output SC_MAX7219RX_rows_OutBUS, SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_intensity_Out,
           SC_MAX7219RX_scanlimit_Out, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_disptest_Out,
           SC_MAX7219RX_word_OutBUS, SC_MAX7219RX_wordvalid_Out, SC_MAX7219RX_frameerr_Out,
           SC_MAX7219RX_dout_Out
  );
`else
  modport master (
    output SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
    input  SC_MAX7219RX_rows_OutBUS, SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_intensity_Out,
           SC_MAX7219RX_scanlimit_Out, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_disptest_Out,
           SC_MAX7219RX_word_OutBUS, SC_MAX7219RX_wordvalid_Out, SC_MAX7219RX_frameerr_Out
  );

  modport slave (
    input  SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
    output SC_MAX7219RX_rows_OutBUS, SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_intensity_Out,
           SC_MAX7219RX_scanlimit_Out, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_disptest_Out,
           SC_MAX7219RX_word_OutBUS, SC_MAX7219RX_wordvalid_Out, SC_MAX7219RX_frameerr_Out
  );
`endif

endinterface

// File: rtl/sc_max7219rx_sync.sv
// Input synchronizer plus one edge flop; level, rise and fall all refer to the synced signal.
module sc_max7219rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Chain resets low so a pin already high at release is not mistaken for a settled ncs=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/sc_max7219rx.sv
// MAX7219 serial receiver and shadow register file. Define SC_MAX7219RX_DOUT_EN for the daisy-chain dout output.
module sc_max7219rx
  import sc_max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 8
) (
  input  logic                  SC_MAX7219RX_CLOCK_50,
  input  logic                  SC_MAX7219RX_RESET_InLow,
  sc_max7219rx_if.slave         bus
);

  logic clk;
  logic rst_n;
  assign clk   = SC_MAX7219RX_CLOCK_50;
  assign rst_n = SC_MAX7219RX_RESET_InLow;

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_rise;
  logic din_lvl;
  logic unused_sclk_lvl, unused_sclk_fall, unused_din_rise, unused_din_fall;

  sc_max7219rx_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_in(bus.SC_MAX7219RX_ncs_In),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  sc_max7219rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(bus.SC_MAX7219RX_sclk_In),
    .level(unused_sclk_lvl), .rise(sclk_rise), .fall(unused_sclk_fall)
  );

  sc_max7219rx_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .async_in(bus.SC_MAX7219RX_din_In),
    .level(din_lvl), .rise(unused_din_rise), .fall(unused_din_fall)
  );

  state_t              state;
  logic [15:0]         shreg;
  logic [4:0]          cnt;
  logic [8*DIGITS-1:0] rows_q;
  logic [7:0]          decode_q;
  logic [3:0]          intensity_q;
  logic [2:0]          scanlimit_q;
  logic                shutdown_q;
  logic                disptest_q;
  logic [15:0]         word_q;
  logic                wordvalid_q;
  logic                frameerr_q;
  logic [3:0]          addr;
  logic [3:0]          slot;

  assign addr = shreg[11:8];
  assign slot = digit_slot(addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_HIGH;
      shreg       <= '0;
      cnt         <= '0;
      rows_q      <= '0;
      decode_q    <= RST_DECODE;
      intensity_q <= RST_INTENSITY;
      scanlimit_q <= RST_SCANLIMIT;
      shutdown_q  <= RST_SHUTDOWN;
      disptest_q  <= RST_DISPTEST;
      word_q      <= '0;
      wordvalid_q <= 1'b0;
      frameerr_q  <= 1'b0;
    end else begin
      wordvalid_q <= 1'b0;
      frameerr_q  <= 1'b0;
      case (state)
        ST_WAIT_HIGH: if (ncs_lvl) state <= ST_IDLE;
        ST_IDLE: begin
          if (ncs_fall) begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A bit arriving together with the ncs rise still belongs to this frame.
          if (sclk_rise) begin
            shreg <= {shreg[14:0], din_lvl};
            if (cnt != 5'd16) cnt <= cnt + 5'd1;
          end
          if (ncs_rise) state <= ST_LATCH;
        end
        ST_LATCH: begin
          state <= ST_IDLE;
          if (cnt == 5'd16) begin
            word_q      <= shreg;
            wordvalid_q <= 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
              if (slot == 4'(k)) rows_q[8*k +: 8] <= shreg[7:0];
            end
            case (addr)
              ADDR_NOOP:      ;
              ADDR_DECODE:    decode_q    <= shreg[7:0];
              ADDR_INTENSITY: intensity_q <= shreg[3:0];
              ADDR_SCANLIMIT: scanlimit_q <= shreg[2:0];
              ADDR_SHUTDOWN:  shutdown_q  <= ~shreg[0];
              ADDR_DISPTEST:  disptest_q  <= shreg[0];
              default:        ;
            endcase
          end else begin
            frameerr_q <= 1'b1;
          end
        end
        default: state <= ST_WAIT_HIGH;
      endcase
    end
  end

  assign bus.SC_MAX7219RX_rows_OutBUS   = rows_q;
  assign bus.SC_MAX7219RX_decode_OutBUS = decode_q;
  assign bus.SC_MAX7219RX_intensity_Out = intensity_q;
  assign bus.SC_MAX7219RX_scanlimit_Out = scanlimit_q;
  assign bus.SC_MAX7219RX_shutdown_Out  = shutdown_q;
  assign bus.SC_MAX7219RX_disptest_Out  = disptest_q;
  assign bus.SC_MAX7219RX_word_OutBUS   = word_q;
  assign bus.SC_MAX7219RX_wordvalid_Out = wordvalid_q;
  assign bus.SC_MAX7219RX_frameerr_Out  = frameerr_q;

`ifdef SC_MAX7219RX_DOUT_EN
  logic shifted_q;
  logic dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifted_q <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      shifted_q <= (state == ST_SHIFT) && sclk_rise;
      if (shifted_q) dout_q <= shreg[15];
    end
  end

  assign bus.SC_MAX7219RX_dout_Out = dout_q;
`endif

endmodule

// File: tb/tb_sc_max7219rx.sv
// Randomized bench for sc_max7219rx against a frame-level register-file model.
module tb_sc_max7219rx;

  localparam int S = 2;
  localparam int D = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sc_max7219rx_if #(.DIGITS(D)) bus();

  sc_max7219rx #(.SYNC_STAGES(S), .DIGITS(D)) dut (
    .SC_MAX7219RX_CLOCK_50   (clk),
    .SC_MAX7219RX_RESET_InLow(rst_n),
    .bus                     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int wv_seen     = 0;
  int fe_seen     = 0;
  bit check_en    = 1'b0;

  logic [7:0]  m_rows [D];
  logic [7:0]  m_decode;
  logic [3:0]  m_int;
  logic [2:0]  m_scan;
  logic        m_shut;
  logic        m_dt;
  logic [15:0] m_word;
  logic        m_wv;
  logic        m_fe;
  logic        m_dout;

  function automatic void model_reset();
    for (int k = 0; k < D; k++) m_rows[k] = 8'h00;
    m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0; m_shut = 1'b1; m_dt = 1'b0;
    m_word = 16'h0000; m_wv = 1'b0; m_fe = 1'b0; m_dout = 1'b0;
  endfunction

  function automatic void model_accept(input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    if (a >= 1 && a <= D) m_rows[a-1] = w[7:0];
    else if (a == 9)  m_decode = w[7:0];
    else if (a == 10) m_int    = w[3:0];
    else if (a == 11) m_scan   = w[2:0];
    else if (a == 12) m_shut   = ~w[0];
    else if (a == 15) m_dt     = w[0];
    m_word = w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8*D-1:0] er;
    if (check_en) begin
      for (int k = 0; k < D; k++) er[8*k +: 8] = m_rows[k];
      check("rows",      64'(bus.SC_MAX7219RX_rows_OutBUS),   64'(er));
      check("decode",    64'(bus.SC_MAX7219RX_decode_OutBUS), 64'(m_decode));
      check("intensity", 64'(bus.SC_MAX7219RX_intensity_Out), 64'(m_int));
      check("scanlimit", 64'(bus.SC_MAX7219RX_scanlimit_Out), 64'(m_scan));
      check("shutdown",  64'(bus.SC_MAX7219RX_shutdown_Out),  64'(m_shut));
      check("disptest",  64'(bus.SC_MAX7219RX_disptest_Out),  64'(m_dt));
      check("word",      64'(bus.SC_MAX7219RX_word_OutBUS),   64'(m_word));
      check("wordvalid", 64'(bus.SC_MAX7219RX_wordvalid_Out), 64'(m_wv));
      check("frameerr",  64'(bus.SC_MAX7219RX_frameerr_Out),  64'(m_fe));
`ifdef SC_MAX7219RX_DOUT_EN
      check("dout",      64'(bus.SC_MAX7219RX_dout_Out),      64'(m_dout));
`endif
      if (bus.SC_MAX7219RX_wordvalid_Out === 1'b1) wv_seen++;
      if (bus.SC_MAX7219RX_frameerr_Out === 1'b1)  fe_seen++;
    end
  end

  function automatic int ur(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  // Inputs always change 2 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

`ifdef SC_MAX7219RX_DOUT_EN
  task automatic sched_dout(input logic b);
    fork
      begin
        automatic logic v = b;
        repeat (S+2) @(posedge clk);
        m_dout = v;
      end
    join_none
  endtask
`endif

  // Sends nbits of bits, MSB first; rst_at > 0 pulses reset after that many bits.
  task automatic send_frame(input logic [63:0] bits, input int nbits, input int rst_at);
    bit          ok;
    logic [15:0] win;
    ok  = 1'b1;
    win = 16'h0000;
    step(1);
    bus.SC_MAX7219RX_ncs_In = 1'b0;
    step(ur(3, 6));
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.SC_MAX7219RX_din_In = bits[i];
      step(ur(3, 6));
      bus.SC_MAX7219RX_sclk_In = 1'b1;
      win = {win[14:0], bits[i]};
`ifdef SC_MAX7219RX_DOUT_EN
      if (ok) sched_dout(win[15]);
`endif
      step(ur(3, 6));
      bus.SC_MAX7219RX_sclk_In = 1'b0;
      if (nbits - i == rst_at) begin
        rst_n = 1'b0;
        model_reset();
        ok = 1'b0;
        step(3);
        rst_n = 1'b1;
      end
    end
    step(ur(3, 6));
    bus.SC_MAX7219RX_ncs_In = 1'b1;
    if (ok) begin
      repeat (S+2) @(posedge clk);
      if (nbits >= 16) begin
        model_accept(bits[15:0]);
        m_wv = 1'b1;
      end else begin
        m_fe = 1'b1;
      end
      @(posedge clk);
      m_wv = 1'b0;
      m_fe = 1'b0;
      #2;
    end else begin
      step(S+4);
    end
    step(ur(2, 5));
  endtask

  task automatic idle_clicks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.SC_MAX7219RX_din_In  = 1'($urandom_range(0, 1));
      bus.SC_MAX7219RX_sclk_In = 1'b1;
      step(3);
      bus.SC_MAX7219RX_sclk_In = 1'b0;
      step(3);
    end
  endtask

  initial begin
    #5ms;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int wv0, fe0;
    logic [63:0] b;
    int nb, sel;

    bus.SC_MAX7219RX_din_In  = 1'b0;
    bus.SC_MAX7219RX_ncs_In  = 1'b1;
    bus.SC_MAX7219RX_sclk_In = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    step(3);
    check_en = 1'b1;
    rst_n = 1'b1;
    step(6);

    // 1: reset state
    check("t1_rows",      64'(bus.SC_MAX7219RX_rows_OutBUS),   64'h0);
    check("t1_shutdown",  64'(bus.SC_MAX7219RX_shutdown_Out),  64'h1);
    check("t1_intensity", 64'(bus.SC_MAX7219RX_intensity_Out), 64'h0);

    // 2: shutdown off, intensity A
    wv0 = wv_seen; fe0 = fe_seen;
    send_frame(64'h0C01, 16, -1);
    send_frame(64'h0A0A, 16, -1);
    check("t2_shutdown",  64'(bus.SC_MAX7219RX_shutdown_Out),  64'h0);
    check("t2_intensity", 64'(bus.SC_MAX7219RX_intensity_Out), 64'hA);
    check("t2_wv_pulses", 64'(wv_seen - wv0), 64'd2);
    check("t2_fe_pulses", 64'(fe_seen - fe0), 64'd0);

    // 3: first and last digit rows
    send_frame(64'h0181, 16, -1);
    send_frame(64'h08FF, 16, -1);
    check("t3_rows", 64'(bus.SC_MAX7219RX_rows_OutBUS), 64'hFF00_0000_0000_0081);

    // 4: short frame, then an over-long frame
    wv0 = wv_seen; fe0 = fe_seen;
    send_frame(64'hABC, 12, -1);
    check("t4_fe_pulse", 64'(fe_seen - fe0), 64'd1);
    check("t4_rows_kept", 64'(bus.SC_MAX7219RX_rows_OutBUS), 64'hFF00_0000_0000_0081);
    send_frame(64'h9_0355, 20, -1);
    check("t4_row3", 64'(bus.SC_MAX7219RX_rows_OutBUS[23:16]), 64'h55);
    check("t4_wv_pulse", 64'(wv_seen - wv0), 64'd1);

    // 5: reset mid-word, then a clean frame
    wv0 = wv_seen;
    send_frame(64'h0C01, 16, 8);
    check("t5_no_wv", 64'(wv_seen - wv0), 64'd0);
    check("t5_shutdown_reset", 64'(bus.SC_MAX7219RX_shutdown_Out), 64'h1);
    send_frame(64'h0F01, 16, -1);
    check("t5_disptest", 64'(bus.SC_MAX7219RX_disptest_Out), 64'h1);

    // 6: 32-bit pass-through frame
    send_frame(64'h0201_0000, 32, -1);
    check("t6_row2", 64'(bus.SC_MAX7219RX_rows_OutBUS[15:8]), 64'h00);
    check("t6_word", 64'(bus.SC_MAX7219RX_word_OutBUS), 64'h0000);

    // Random frames with stray clocks while deselected
    for (int n = 0; n < 60; n++) begin
      b   = {$urandom, $urandom};
      sel = ur(0, 9);
      if (sel == 0)      nb = ur(0, 15);
      else if (sel == 1) nb = ur(17, 24);
      else               nb = 16;
      if (ur(0, 3) == 0) idle_clicks(ur(1, 3));
      send_frame(b, nb, -1);
    end

    step(4);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
